// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Latency: start in cycle 0 -> done pulse and new HI/LO in cycle WIDTH+2.
// Backpressure: none; start and MTHI/MTLO are ignored while busy, and the caller stalls on busy.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW        = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // Operation context captured at start
  logic               r_is_div;
  logic               r_neg_a;
  logic               r_neg_b;
  logic [CW-1:0]      r_cnt;
  // Multiply: r_q = multiplier (shifts right), r_acc = running product.
  // Divide:   r_q = dividend bits shifting out / quotient bits shifting in,
  //           r_acc[WIDTH-1:0] = partial remainder.
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_mag_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_signed;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  // op[0]=0 selects the signed variants (MULT, DIV)
  assign w_signed = ~op[0];
  assign w_mag_a  = (w_signed && a[WIDTH-1]) ? -a : a;
  assign w_mag_b  = (w_signed && b[WIDTH-1]) ? -b : b;

  // Shift-add step: add multiplicand into the upper half, then shift right one bit
  assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_q[0] ? r_mag_b : {WIDTH{1'b0}})};

  // Restoring-division step: bring in the next dividend bit and trial-subtract
  assign w_shift = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_mag_b});
  // When w_ge holds the difference is below the divisor, so WIDTH bits suffice
  assign w_diff  = w_shift[WIDTH-1:0] - r_mag_b;

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: IDLE -> CALC for WIDTH iterations -> FIX -> IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CALC;
      S_CALC:  if (r_cnt == LAST_ITER) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Sign correction of the unsigned magnitude result for the FIX cycle.
  // Divide by zero: every trial subtract succeeds, so the quotient is all ones
  // and the remainder ends up as |a|; re-applying a's sign restores a itself.
  // Only lo needs forcing so the quotient sign flip cannot touch it.
  always_comb begin
    w_prod   = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      w_res_lo = (r_neg_a ^ r_neg_b) ? -r_q : r_q;
      w_res_hi = r_neg_a ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      if (r_mag_b == {WIDTH{1'b0}}) begin
        w_res_lo = {WIDTH{1'b1}};
      end
    end
  end

  // Datapath, HI/LO and done: capture at start, iterate in CALC, commit in FIX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_div <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_cnt    <= '0;
      r_q      <= '0;
      r_mag_b  <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // MTHI/MTLO land even alongside start; the result overwrites them later
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
          if (start) begin
            r_is_div <= op[1];
            r_neg_a  <= w_signed & a[WIDTH-1];
            r_neg_b  <= w_signed & b[WIDTH-1];
            r_q      <= w_mag_a;
            r_mag_b  <= w_mag_b;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_is_div) begin
            r_acc[WIDTH-1:0] <= w_ge ? w_diff : w_shift[WIDTH-1:0];
            r_q              <= {r_q[WIDTH-2:0], w_ge};
          end else begin
            r_acc <= {w_sum, r_acc[WIDTH-1:1]};
            r_q   <= {1'b0, r_q[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          r_hi   <= w_res_hi;
          r_lo   <= w_res_lo;
          r_done <= 1'b1;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit at WIDTH=32 and WIDTH=8.
// Cycle k is the interval after the k-th rising edge following the start cycle.
// Inputs are driven and outputs sampled 1ns after the rising edge.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic        start8, hi_we8, lo_we8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, wdata8;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .hi_we(hi_we8), .lo_we(lo_we8), .wdata(wdata8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present start for one cycle, then scramble op/a/b to show they are not re-sampled
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    op = ~o; a = 32'h5A5A5A5A; b = 32'h0F0F0F0F;
  endtask

  // Advance until done, counting cycles from 'from'; bounded at 200
  task automatic wait_done(input int from, output int cyc, output logic busy_ok);
    cyc = from;
    busy_ok = 1'b1;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
      cyc++;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int   c;
    logic bok;
    start_op(o, x, y);
    wait_done(1, c, bok);
    check({name, "_cycle"}, c, 34);
    check({name, "_busy_run"}, {31'b0, bok}, 1);
    check({name, "_busy_done"}, {31'b0, busy}, 0);
    check({name, "_hi"}, hi, exp_hi);
    check({name, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    int   c;
    int   pulses;
    logic bok;

    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0; hi_we8 = 1'b0; lo_we8 = 1'b0; wdata8 = '0;
    tick();
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    tick();
    rst = 1'b0;
    tick();

    // Each op starts in the done cycle of the previous one (back-to-back acceptance)
    run_op("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    tick();
    check("done_one_cycle", {31'b0, done}, 0);
    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_negneg", OP_MULT, 32'hFFFFFFFC, 32'hFFFFFFFA, 32'h0, 32'd24);
    run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_op("divu_zero", OP_DIVU, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF);

    // start and MTHI while busy are ignored
    start_op(OP_MULTU, 32'd3, 32'd4);
    repeat (9) tick();
    op = OP_DIV; a = 32'd100; b = 32'd7; start = 1'b1; hi_we = 1'b1; wdata = 32'hDEADBEEF;
    tick();
    start = 1'b0; hi_we = 1'b0;
    check("busy_mthi_ignored", hi, 32'h1234);
    check("busy_still", {31'b0, busy}, 1);
    wait_done(11, c, bok);
    check("busy_start_cycle", c, 34);
    check("busy_start_hi", hi, 32'h0);
    check("busy_start_lo", lo, 32'd12);

    // Start in the done cycle together with MTHI: write lands, result overwrites it
    op = OP_MULTU; a = 32'd6; b = 32'd7; start = 1'b1; hi_we = 1'b1; wdata = 32'h55;
    tick();
    start = 1'b0; hi_we = 1'b0; a = '0; b = '0;
    check("mthi_with_start", hi, 32'h55);
    check("b2b_busy", {31'b0, busy}, 1);
    wait_done(1, c, bok);
    check("b2b_cycle", c, 34);
    check("b2b_hi", hi, 32'h0);
    check("b2b_lo", lo, 32'd42);

    // MTLO while idle
    tick();
    lo_we = 1'b1; wdata = 32'hA5;
    tick();
    lo_we = 1'b0;
    check("mtlo_lo", lo, 32'hA5);
    check("mtlo_hi_held", hi, 32'h0);

    // Reset in the middle of a DIV
    hi_we = 1'b1; wdata = 32'h77;
    tick();
    hi_we = 1'b0;
    check("mthi_idle", hi, 32'h77);
    start_op(OP_DIV, 32'd1000, 32'd3);
    repeat (14) tick();
    rst = 1'b1;
    #1;
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_busy", {31'b0, busy}, 0);
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) pulses++;
      tick();
    end
    check("midrst_no_done", pulses, 0);
    check("midrst_idle", {31'b0, busy}, 0);

    // WIDTH=8: MULT -3 x 5
    op8 = OP_MULT; a8 = 8'hFD; b8 = 8'h05; start8 = 1'b1;
    tick();
    start8 = 1'b0; a8 = '0; b8 = '0;
    c = 1;
    while (done8 !== 1'b1 && c < 100) begin
      tick();
      c++;
    end
    check("w8_cycle", c, 10);
    check("w8_hi", {24'b0, hi8}, 32'hFF);
    check("w8_lo", {24'b0, lo8}, 32'hF1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle MIPS multiply/divide unit. It sits downstream of the ALU operand path and consumes the same rs/rt operands the ALU sees.
- Owns the HI/LO register pair and executes MULT, MULTU, DIV and DIVU iteratively, one bit per cycle.
- Also accepts MTHI/MTLO writes.
- Exposes busy/done so the pipeline control can stall MFHI/MFLO until a result is ready.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be ≥ 4.

Ports:
- clk    input   1      rising-edge clock
- rst    input   1      asynchronous, active-high reset
- start  input   1      begin operation; sampled only when busy=0
- op     input   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a      input   WIDTH  rs operand (multiplicand / dividend)
- b      input   WIDTH  rt operand (multiplier / divisor)
- hi_we  input   1      MTHI write strobe
- lo_we  input   1      MTLO write strobe
- wdata  input   WIDTH  MTHI/MTLO data
- busy   output  1      operation in progress
- done   output  1      one-cycle pulse; hi/lo hold the new result
- hi     output  WIDTH  HI register
- lo     output  WIDTH  LO register

Behaviour:
- Reset, asynchronous: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, all internal datapath registers 0.
- FSM states are IDLE, CALC and FIX. busy=1 exactly in CALC and FIX. done is registered.
- IDLE with start=1:
  - latch op, sign flags and magnitudes. Signed ops use |a| and |b|; unsigned ops use a and b as-is.
  - counter←0; go to CALC.
- CALC: one iteration per cycle, for WIDTH cycles, then go to FIX.
  - Multiply: shift-add, producing a 2·WIDTH-bit unsigned product.
  - Divide: restoring division, producing an unsigned quotient and remainder.
- FIX: apply the sign, write hi/lo, done←1, go to IDLE.
  - MULT: negate the 2·WIDTH product if sign(a)≠sign(b). hi=upper half, lo=lower half.
  - DIV: quotient negated if sign(a)≠sign(b); remainder takes the sign of a. lo=quotient, hi=remainder.
  - Unsigned ops: no correction.
- Latency: start high in cycle 0 → done=1 and new hi/lo visible in cycle WIDTH+2. done is high for exactly one cycle, and busy=0 in that cycle.
- Back-to-back: start may be asserted in the done cycle and is accepted.
- start while busy: ignored; no queueing, no effect on the current operation.
- Divide by zero: lo=all ones, hi=a (the original dividend, unsigned or signed), same latency.
- Signed overflow case: DIV of the most negative value by −1 gives lo=most negative value, hi=0.
- hi_we/lo_we:
  - Effective only when busy=0. hi←wdata / lo←wdata at the clock edge.
  - Ignored while busy.
  - If asserted together with start, the write happens and the later result overwrites it.
- hi/lo are otherwise held; a read never has side effects.
- Reset mid-operation: aborts to IDLE with all outputs at reset values; done is never emitted for the aborted operation.
- op, a and b may change after the start cycle without affecting the result.

Test Plan:
1. MULT a=0xFFFFFFFD (−3), b=5 → done at cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high in cycles 1–33.
2. MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. DIVU a=100, b=7 → lo=14, hi=2.
3. DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
4. DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234, done at cycle 34.
5. Start a MULTU 3×4, then pulse start with op=DIV and hi_we=1 at cycle 10:
   - at cycle 10, neither the new start nor the HI write takes effect;
   - result is hi=0, lo=12;
   - a start in the done cycle is accepted;
   - MTLO wdata=0xA5 while idle → lo=0xA5 next cycle.
6. Assert rst in cycle 15 of a DIV → hi=lo=0, busy=0 immediately, no done pulse. Rerun with WIDTH=8: MULT −3×5 → hi=0xFF, lo=0xF1, done at cycle 10.
